vector_write_module: RTL and testbench

// - Store-side counterpart of the vector load path: writes one scalar or a full
//   I-item vector to data memory, one item per clock at consecutive addresses.
// - Sits between the vector register file and the data-memory write port.
// - Driven by the execute stage's store control.
// - Pulses finished when the last item is written, so the pipeline can advance.

---
 rtl/vector_write_module_pkg.sv | 21 ++
 rtl/vector_write_module_if.sv | 36 +++
 rtl/vector_write_module_wr_counter.sv | 36 +++
 rtl/vector_write_module.sv | 108 ++++++++++
 tb/tb_vector_write_module.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/vector_write_module_pkg.sv
// Shared types and default sizes for the vector store path.
// No logic: constants, operation encoding and store FSM state encoding.
// No flow control lives here.
package vec_pkg;

    localparam int VEC_ITEMS = 20;
    localparam int ITEM_W    = 32;
    localparam int ADDR_W    = 6;

    typedef enum logic {
        OP_SCALAR = 1'b0,
        OP_VECTOR = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WRITE = 2'd1,
        WR_DONE  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/vector_write_module_if.sv
// Store request plus data-memory write port bundle for the vector store path.
// Pure wiring, no latency.
// Requests are dropped while busy is high; the write port has no backpressure.
interface vector_write_if
    import vec_pkg::*;
#(
    parameter int I = VEC_ITEMS,
    parameter int L = ITEM_W,
    parameter int A = ADDR_W
) ();

    logic                  start;
    logic                  op_type;
    logic [A-1:0]          base_address;
    logic [L-1:0]          scalar_data;
    logic [I-1:0][L-1:0]   vector_data;

    logic                  write_enable;
    logic [A-1:0]          write_address;
    logic [L-1:0]          write_data;
    logic                  busy;
    logic                  finished;

    // Execute-stage side: issues the store and watches busy/finished.
    modport master (
        output start, op_type, base_address, scalar_data, vector_data,
        input  write_enable, write_address, write_data, busy, finished
    );

    // Store engine side.
    modport slave (
        input  start, op_type, base_address, scalar_data, vector_data,
        output write_enable, write_address, write_data, busy, finished
    );

endinterface

// File: rtl/vector_write_module_wr_counter.sv
// Item index register for the store engine: clear wins over enable.
// Index updates one cycle after clear/enable are sampled.
// No backpressure; the owner decides when to step it.
module wr_counter #(
    parameter int A = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [A-1:0] index
);

    logic [A-1:0] index_q;
    logic [A-1:0] index_d;

    always_comb begin
        index_d = index_q;
        if (clear) begin
            index_d = '0;
        end else if (enable) begin
            index_d = index_q + A'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    assign index = index_q;

endmodule

// File: rtl/vector_write_module.sv
// Writes a captured scalar or I-item vector to data memory, one item per clock.
// Writes start the cycle after start is taken; finished pulses the cycle after the last write.
// start is ignored (not queued) while busy; the memory port never stalls.
module vector_write_module
    import vec_pkg::*;
#(
    parameter int I = VEC_ITEMS,
    parameter int L = ITEM_W,
    parameter int A = ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    vector_write_if.slave  bus
);

    if (I > (1 << A)) begin : g_bad_size
        $error("vector_write_module: I=%0d items do not fit in a %0d-bit address space", I, A);
    end

    localparam logic [A-1:0] LAST_VEC = A'(I - 1);

    wr_state_t           state_q, state_d;
    op_t                 op_q, op_d;
    logic [A-1:0]        base_q, base_d;
    logic [I-1:0][L-1:0] shadow_q, shadow_d;

    logic [A-1:0]        index;
    logic [A-1:0]        last_index;
    logic [L-1:0]        item;
    logic                in_write;

    assign in_write   = (state_q == WR_WRITE);
    assign last_index = (op_q == OP_VECTOR) ? LAST_VEC : '0;

    // Index is held at zero outside WRITE so every store begins at item 0.
    wr_counter #(
        .A (A)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_write),
        .enable (in_write),
        .index  (index)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        base_d   = base_q;
        shadow_d = shadow_q;
        case (state_q)
            WR_IDLE: begin
                if (bus.start) begin
                    state_d = WR_WRITE;
                    op_d    = op_t'(bus.op_type);
                    base_d  = bus.base_address;
                    if (bus.op_type == OP_VECTOR) begin
                        shadow_d = bus.vector_data;
                    end else begin
                        shadow_d[0] = bus.scalar_data;
                    end
                end
            end
            WR_WRITE: begin
                if (index == last_index) begin
                    state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                state_d = WR_IDLE;
            end
            default: begin
                state_d = WR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WR_IDLE;
            op_q     <= OP_SCALAR;
            base_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            base_q   <= base_d;
            shadow_q <= shadow_d;
        end
    end

    // Explicit compare-select keeps the lookup in range for any index value.
    always_comb begin
        item = '0;
        for (int n = 0; n < I; n++) begin
            if (index == A'(n)) begin
                item = shadow_q[n];
            end
        end
    end

    assign bus.write_enable  = in_write;
    assign bus.write_address = in_write ? (base_q + index) : '0;
    assign bus.write_data    = in_write ? item : '0;
    assign bus.busy          = (state_q != WR_IDLE);
    assign bus.finished      = (state_q == WR_DONE);

endmodule

// File: tb/tb_vector_write_module.sv
module tb_vector_write_module;

    localparam int I = 20;
    localparam int L = 32;
    localparam int A = 6;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    vector_write_if #(.I(I), .L(L), .A(A)) bus ();

    vector_write_module #(.I(I), .L(L), .A(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_we"},   64'(bus.write_enable),  64'd0);
        check({tag, "_addr"}, 64'(bus.write_address), 64'd0);
        check({tag, "_data"}, 64'(bus.write_data),    64'd0);
        check({tag, "_busy"}, 64'(bus.busy),          64'd0);
        check({tag, "_fin"},  64'(bus.finished),      64'd0);
    endtask

    // Issues at a negedge; on return we sit at the negedge of the first idle cycle.
    task automatic scalar_store(input logic [A-1:0] base, input logic [L-1:0] val);
        bus.op_type      = 1'b0;
        bus.base_address = base;
        bus.scalar_data  = val;
        for (int m = 0; m < I; m++) bus.vector_data[m] = 32'h5555_0000 + 32'(m);
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.scalar_data = ~val;
        check("sc_we",   64'(bus.write_enable),  64'd1);
        check("sc_addr", 64'(bus.write_address), 64'(base));
        check("sc_data", 64'(bus.write_data),    64'(val));
        check("sc_busy", 64'(bus.busy),          64'd1);
        check("sc_fin0", 64'(bus.finished),      64'd0);
        @(negedge clk);
        check("sc_fin",      64'(bus.finished),     64'd1);
        check("sc_done_we",  64'(bus.write_enable), 64'd0);
        check("sc_done_bsy", 64'(bus.busy),         64'd1);
        @(negedge clk);
        check_idle("sc_after");
    endtask

    // disturb_at: re-pulse start with new inputs at that item (and in the DONE cycle).
    // rst_at: assert reset right after that item's write is observed.
    task automatic vec_store(input logic [A-1:0] base, input logic [L-1:0] seed,
                             input int disturb_at, input int rst_at);
        logic [L-1:0] exp_d [I];
        logic [A-1:0] exp_a;
        bit           aborted;
        aborted = 1'b0;
        for (int m = 0; m < I; m++) begin
            exp_d[m] = seed + 32'(m);
            bus.vector_data[m] = exp_d[m];
        end
        bus.op_type      = 1'b1;
        bus.base_address = base;
        bus.scalar_data  = 32'hFFFF_FFFF;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n < I; n++) begin
            exp_a = base + 6'(n);
            check($sformatf("vec_we[%0d]", n),   64'(bus.write_enable),  64'd1);
            check($sformatf("vec_addr[%0d]", n), 64'(bus.write_address), 64'(exp_a));
            check($sformatf("vec_data[%0d]", n), 64'(bus.write_data),    64'(exp_d[n]));
            check($sformatf("vec_busy[%0d]", n), 64'(bus.busy),          64'd1);
            check($sformatf("vec_fin[%0d]", n),  64'(bus.finished),      64'd0);
            if (n == disturb_at) begin
                bus.start        = 1'b1;
                bus.op_type      = 1'b0;
                bus.base_address = base + 6'd17;
                for (int m = 0; m < I; m++) bus.vector_data[m] = 32'hBAD0_0000 + 32'(m);
            end else begin
                bus.start = 1'b0;
            end
            if (n == rst_at) begin
                #1 rst = 1'b1;
                #1 check_idle("rst_mid");
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (aborted) begin
            repeat (3) begin
                @(negedge clk);
                check("rst_hold_fin", 64'(bus.finished),     64'd0);
                check("rst_hold_we",  64'(bus.write_enable), 64'd0);
            end
            rst = 1'b0;
            @(negedge clk);
            check_idle("rst_released");
        end else begin
            check("vec_done_fin",  64'(bus.finished),      64'd1);
            check("vec_done_we",   64'(bus.write_enable),  64'd0);
            check("vec_done_busy", 64'(bus.busy),          64'd1);
            check("vec_done_addr", 64'(bus.write_address), 64'd0);
            if (disturb_at >= 0) bus.start = 1'b1;
            @(negedge clk);
            check_idle("vec_after");
            bus.start = 1'b0;
            @(negedge clk);
            check_idle("vec_after2");
        end
    endtask

    initial begin
        rst              = 1'b0;
        bus.start        = 1'b0;
        bus.op_type      = 1'b0;
        bus.base_address = '0;
        bus.scalar_data  = '0;
        bus.vector_data  = '0;

        // Reset asserted mid-cycle clears outputs without waiting for an edge.
        #2 rst = 1'b1;
        #1 check_idle("rst_async");
        repeat (3) begin
            @(negedge clk);
            check_idle("rst_hold");
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        scalar_store(6'd5, 32'hDEAD_BEEF);
        scalar_store(6'd63, 32'h1234_5678);

        vec_store(6'd0, 32'd100, -1, -1);
        vec_store(6'd60, 32'hA000_0000, -1, -1);
        vec_store(6'd10, 32'hC0DE_0000, 5, -1);
        vec_store(6'd3, 32'h7000_0000, -1, 7);
        vec_store(6'd0, 32'd100, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
